// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer
//
// Sequences the UART calculator: collects a three-word command (operand A,
// operand B, op word) from word_rx, presents the operands to the
// combinational alu, captures the 64-bit result and hands result_lo
// (optionally followed by result_hi) to word_tx one word at a time.
// A partially received command is abandoned if the gap between two of its
// words exceeds TIMEOUT_CYCLES. Words that arrive while a result is being
// computed or sent are discarded and counted.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles between consecutive words of one command (>= 2)
//   SEND_HI         1: send result_hi after result_lo, 0: result_lo only
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   word_in       received word, qualified by the word_done pulse
//   result_lo/hi  alu result for the current operand_a/operand_b/op_select
//   send_done     word_tx finished sending the current word
//   operand_a/b   registered alu operands
//   op_select     registered alu operation (low 4 bits of the op word)
//   word_out      word for word_tx, held from word_send until send_done
//   word_send     one-cycle start pulse to word_tx
//   busy          high while a command executes or its result is sent
//   timeout_err   one-cycle pulse when a partial command is abandoned
//   drop_count    saturating count of words discarded while busy

module calc_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit SEND_HI        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_done,
  input  logic [31:0] result_lo,
  input  logic [31:0] result_hi,
  input  logic        send_done,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic [3:0]  op_select,
  output logic [31:0] word_out,
  output logic        word_send,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RX_A, ST_RX_B, ST_RX_OP, ST_EXEC,
    ST_SEND_LO, ST_WAIT_LO, ST_SEND_HI, ST_WAIT_HI
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   operand_a_reg, operand_a_next;
  logic [31:0]   operand_b_reg, operand_b_next;
  logic [3:0]    op_select_reg, op_select_next;
  logic [31:0]   hi_reg, hi_next;
  logic [31:0]   word_out_reg, word_out_next;
  logic          word_send_reg, word_send_next;
  logic          busy_reg, busy_next;
  logic [7:0]    drop_reg, drop_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          timeout_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RX_A;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      op_select_reg <= '0;
      hi_reg        <= '0;
      word_out_reg  <= '0;
      word_send_reg <= 1'b0;
      busy_reg      <= 1'b0;
      drop_reg      <= '0;
      timer_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      operand_a_reg <= operand_a_next;
      operand_b_reg <= operand_b_next;
      op_select_reg <= op_select_next;
      hi_reg        <= hi_next;
      word_out_reg  <= word_out_next;
      word_send_reg <= word_send_next;
      busy_reg      <= busy_next;
      drop_reg      <= drop_next;
      timer_reg     <= timer_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    operand_a_next = operand_a_reg;
    operand_b_next = operand_b_reg;
    op_select_next = op_select_reg;
    hi_next        = hi_reg;
    word_out_next  = word_out_reg;
    word_send_next = 1'b0;
    drop_next      = drop_reg;
    timer_next     = timer_reg;
    timeout_fire   = 1'b0;

    case (state_reg)
      ST_RX_A: begin
        if (word_done) begin
          operand_a_next = word_in;
          timer_next     = '0;
          state_next     = ST_RX_B;
        end
      end
      ST_RX_B, ST_RX_OP: begin
        // A word arriving on the expiry cycle still counts, so word_done
        // is checked before the timer.
        if (word_done) begin
          timer_next = '0;
          if (state_reg == ST_RX_B) begin
            operand_b_next = word_in;
            state_next     = ST_RX_OP;
          end else begin
            op_select_next = word_in[3:0];
            state_next     = ST_EXEC;
          end
        end else if (timer_reg == TIMER_LAST) begin
          timeout_fire = 1'b1;
          timer_next   = '0;
          state_next   = ST_RX_A;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_EXEC: begin
        // The operands have been stable for one full cycle: take the result.
        hi_next        = result_hi;
        word_out_next  = result_lo;
        word_send_next = 1'b1;
        state_next     = ST_SEND_LO;
      end
      ST_SEND_LO: state_next = ST_WAIT_LO;
      ST_WAIT_LO: begin
        if (send_done) begin
          if (SEND_HI) begin
            word_out_next  = hi_reg;
            word_send_next = 1'b1;
            state_next     = ST_SEND_HI;
          end else begin
            state_next = ST_RX_A;
          end
        end
      end
      ST_SEND_HI: state_next = ST_WAIT_HI;
      ST_WAIT_HI: begin
        if (send_done) state_next = ST_RX_A;
      end
      default: state_next = ST_RX_A;
    endcase

    // busy_reg marks every state that does not accept words, including
    // the WAIT_* cycle in which send_done arrives.
    if (word_done && busy_reg && (drop_reg != 8'hFF)) drop_next = drop_reg + 8'd1;

    busy_next = state_next inside {ST_EXEC, ST_SEND_LO, ST_WAIT_LO, ST_SEND_HI, ST_WAIT_HI};
  end

  assign operand_a   = operand_a_reg;
  assign operand_b   = operand_b_reg;
  assign op_select   = op_select_reg;
  assign word_out    = word_out_reg;
  assign word_send   = word_send_reg;
  assign busy        = busy_reg;
  assign drop_count  = drop_reg;
  // Flagged in the cycle the command is abandoned; reset suppresses it.
  assign timeout_err = timeout_fire & ~rst;

endmodule
